tdm_clock_ctrl: RTL

Master-side clock and frame sequencer for the 4-slot TDM microphone array. It divides the system clock to produce the serial clock and the word-select pulse that drive the microphones and the TDM receiver. It gates streaming on and off only at frame boundaries and publishes slot/bit position strobes and a frame counter for downstream beamforming logic. It sits between the system clock domain and the mic/receiver pins.

---
 rtl/tdm_clock_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/tdm_clock_ctrl.sv
// Master clock/frame sequencer for a TDM microphone array: divides clk_in into sck, places the
// word-select lead-in period, and starts/stops streaming only on frame boundaries.
module tdm_clock_ctrl #(
    parameter int unsigned SLOTS       = 4,
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned HALF_PERIOD = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    output logic        sck_out,
    output logic        ws_out,
    output logic        sck_rise_out,
    output logic        frame_start_out,
    output logic [2:0]  slot_idx_out,
    output logic [5:0]  bit_idx_out,
    output logic [15:0] frame_count_out,
    output logic        busy_out
);

    localparam int unsigned FRAME_BITS = SLOTS * SLOT_BITS;
    localparam int unsigned PW         = $clog2(FRAME_BITS);
    localparam int unsigned DW         = $clog2(HALF_PERIOD);
    localparam int unsigned SBW        = $clog2(SLOT_BITS);

    localparam logic [PW-1:0] PosLast = PW'(FRAME_BITS - 1);
    localparam logic [PW-1:0] PosPen  = PW'(FRAME_BITS - 2);
    localparam logic [DW-1:0] DivLast = DW'(HALF_PERIOD - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [PW-1:0] pos_next;
    logic [15:0]   fcnt_q, fcnt_d;
    logic          sck_q, sck_d;
    logic          ws_q, ws_d;
    logic          rise_q, rise_d;
    logic          fs_q, fs_d;
    logic          tick;
    logic          stop;

    assign tick     = (div_q == DivLast);
    assign pos_next = (pos_q == PosLast) ? '0 : pos_q + PW'(1);
    // Stop only on the fall that would enter the lead-in period, so the frame is never cut short.
    assign stop     = tick && sck_q && (pos_q == PosPen) && !enable_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable_in) state_d = StRun;
            StRun:  if (stop)      state_d = StIdle;
        endcase
    end

    always_comb begin
        div_d  = div_q;
        sck_d  = sck_q;
        ws_d   = ws_q;
        pos_d  = pos_q;
        fcnt_d = fcnt_q;
        rise_d = 1'b0;
        fs_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                div_d = '0;
                sck_d = 1'b0;
                pos_d = PosLast;
                ws_d  = enable_in;
            end
            StRun: begin
                if (tick) begin
                    div_d = '0;
                    sck_d = !sck_q;
                    if (!sck_q) begin
                        rise_d = 1'b1;
                    end else if (stop) begin
                        ws_d  = 1'b0;
                        pos_d = PosLast;
                    end else begin
                        pos_d = pos_next;
                        ws_d  = (pos_next == PosLast);
                        if (pos_next == '0) begin
                            fs_d   = 1'b1;
                            fcnt_d = fcnt_q + 16'd1;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_q  <= '0;
            sck_q  <= 1'b0;
            ws_q   <= 1'b0;
            pos_q  <= PosLast;
            fcnt_q <= '0;
            rise_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            sck_q  <= sck_d;
            ws_q   <= ws_d;
            pos_q  <= pos_d;
            fcnt_q <= fcnt_d;
            rise_q <= rise_d;
            fs_q   <= fs_d;
        end
    end

    assign sck_out         = sck_q;
    assign ws_out          = ws_q;
    assign sck_rise_out    = rise_q;
    assign frame_start_out = fs_q;
    assign frame_count_out = fcnt_q;
    assign busy_out        = (state_q == StRun);
    // SLOT_BITS is a power of two, so slot/bit are a plain split of pos.
    assign slot_idx_out    = 3'(pos_q >> SBW);
    assign bit_idx_out     = 6'(pos_q & PW'(SLOT_BITS - 1));

endmodule
